// File: rtl/alu16_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Operands are latched at grant; the result is registered and handed back with a done pulse.
module alu16_arbiter #(
    parameter int WIDTH = 16,
    parameter int CTLW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [CTLW-1:0]  ctl0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [CTLW-1:0]  ctl1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [CTLW-1:0]  alu_ctl,
    input  logic [WIDTH-1:0] alu_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             prio;
    logic             gnt;
    logic             take;
    logic             sel;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CTLW-1:0]  ctl_q;
    logic [WIDTH-1:0] res_q;

    // With both requesting, prio decides; otherwise the lone requester wins.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        sel     = prio;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    take    = 1'b1;
                    sel     = (req0 && req1) ? prio : req1;
                    state_n = EXEC;
                end
            end
            EXEC:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            gnt   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            ctl_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                gnt   <= sel;
                a_q   <= sel ? a1 : a0;
                b_q   <= sel ? b1 : b0;
                ctl_q <= sel ? ctl1 : ctl0;
            end
            if (state == EXEC) begin
                res_q <= alu_y;
            end
            if (state == DONE) begin
                prio <= ~gnt;
            end
        end
    end

    // Done is decoded from state so a reset clears it without waiting for an edge.
    assign done0   = (state == DONE) && !gnt;
    assign done1   = (state == DONE) && gnt;
    assign busy    = (state != IDLE);
    assign result  = res_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_ctl = ctl_q;

endmodule

// File: doc/alu16_arbiter.md
Name: alu16_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational 16-bit ALU (built from the 16-bit gate library) between two requesters. It latches the winning requester's operands and control word, drives the ALU, and registers the result. It then returns the result with a one-cycle done pulse to that requester. It sits between the CPU datapath (requester 0) and the I/O/DMA engine (requester 1) and the shared ALU.

Parameters:
WIDTH, 16, operand/result width
CTLW, 6, ALU control word width (zx, nx, zy, ny, f, no)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 request, held until done0
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
ctl0  input  CTLW  requester 0 ALU control
req1  input  1  requester 1 request, held until done1
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
ctl1  input  CTLW  requester 1 ALU control
done0  output  1  one-cycle pulse; result valid for requester 0
done1  output  1  one-cycle pulse; result valid for requester 1
result  output  WIDTH  registered ALU result, held until next capture
busy  output  1  high in EXEC and DONE
alu_a  output  WIDTH  to shared ALU operand A
alu_b  output  WIDTH  to shared ALU operand B
alu_ctl  output  CTLW  to shared ALU control
alu_y  input  WIDTH  from shared ALU, combinational result

Behaviour:
- Reset (async, rst=1): state=IDLE, prio=0, done0=done1=0, busy=0, result=0, latched a/b/ctl=0, gnt=0. Reset is effective immediately, not at the next edge.
- alu_a, alu_b and alu_ctl are always driven from the latched operand registers (0 after reset), never directly from requester inputs.
- FSM: IDLE -> EXEC -> DONE -> IDLE. Fixed 3 cycles per operation; max throughput one op per 3 cycles.
- IDLE:
  - No req: stay.
  - Exactly one req: grant it.
  - Both req: grant the requester equal to prio.
  - On grant: latch a/b/ctl of the winner and gnt, then go to EXEC.
- EXEC: ALU sees the latched operands. At the clock edge, result <= alu_y; go to DONE.
- DONE:
  - done[gnt]=1 for exactly this cycle; result is stable.
  - prio <= ~gnt (the loser of the last grant gets priority).
  - Go to IDLE.
- busy = (state != IDLE).
- Requester protocol:
  - The requester deasserts req in the cycle after it sees done.
  - If req is still high in the following IDLE cycle, it is a new request and is arbitrated normally (back-to-back is allowed).
- Req dropped during EXEC/DONE: no abort. The operation completes and done still pulses.
- Input changes on a/b/ctl after the grant are ignored until the next grant.
- Never both done0 and done1 high at once. done is never high outside DONE.
- Mid-operation reset: the operation is discarded, no done is issued, and state returns to IDLE with the reset values above.
- No width conversion: result is exactly alu_y[WIDTH-1:0].

Test Plan:
- Reset, then req0=1, a0=16'h0005, b0=16'h0003, ctl0=6'b000010 (x+y), bench ALU model -> alu_a=0005/alu_b=0003 in EXEC; done0 pulses 2 cycles after grant edge; result=16'h0008; done1 never asserted.
- req0 and req1 both asserted in the same cycle after reset -> requester 0 served first (done0); requester 1 served next (done1). Gap between done pulses = 3 cycles.
- Both reqs held high continuously for 6 operations -> grants alternate 0,1,0,1,0,1; busy low exactly one cycle between ops.
- req1 alone twice back-to-back (req held through DONE) -> two done1 pulses 3 cycles apart; prio toggles but requester 1 still wins when alone.
- req0 granted, then a0 changed to 16'hFFFF and req0 dropped during EXEC -> result uses the original latched a0; done0 still pulses once.
- rst asserted during EXEC -> done0/done1/busy/result go to 0 immediately; no done pulse after release. A fresh req1 is then served normally with prio=0 semantics.
